// File: rtl/bch_encode_sched.sv
`default_nettype none
// ============================================================================
// bch_encode_sched : two-requester round-robin owner of one bch_encode core
// Revision 1.0
// ============================================================================
module bch_encode_sched #(
  parameter int BITS       = 1,
  parameter int DATA_WORDS = 5,
  parameter int DRAIN_MAX  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  output logic [1:0]        gnt,
  input  logic [1:0]        in_valid,
  input  logic [2*BITS-1:0] in_data,
  output logic [1:0]        in_ready,
  output logic              enc_start,
  output logic              enc_ce,
  output logic [BITS-1:0]   enc_data_in,
  input  logic              enc_ready,
  input  logic [BITS-1:0]   enc_data_out,
  input  logic              enc_first,
  input  logic              enc_last,
  input  logic              enc_data_bits,
  input  logic              enc_ecc_bits,
  output logic              out_valid,
  output logic [BITS-1:0]   out_data,
  output logic              out_first,
  output logic              out_last,
  output logic              out_ecc,
  output logic              out_id,
  output logic              timeout
);

  localparam int WCNT_W = $clog2(DATA_WORDS);
  localparam int DCNT_W = $clog2(DRAIN_MAX + 1);
  localparam logic [WCNT_W-1:0] C_WLAST = WCNT_W'(DATA_WORDS - 1);
  localparam logic [DCNT_W-1:0] C_DLAST = DCNT_W'(DRAIN_MAX - 1);
  localparam logic [WCNT_W-1:0] C_WONE  = WCNT_W'(1);
  localparam logic [DCNT_W-1:0] C_DONE  = DCNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_rr;
  logic              r_owner;
  logic [1:0]        r_gnt;
  logic              r_timeout;
  logic [WCNT_W-1:0] r_wcnt;
  logic [DCNT_W-1:0] r_dcnt;

  logic w_load;
  logic w_drain;
  logic w_pick;
  logic w_accept;
  logic w_qual;

  assign w_load   = (r_state == S_LOAD);
  assign w_drain  = (r_state == S_DRAIN);
  // Pointer side wins a tie; otherwise whichever single requester is asking.
  assign w_pick   = req[r_rr] ? r_rr : ~r_rr;
  assign w_accept = w_load & in_valid[r_owner];

  assign enc_ce      = w_accept | w_drain;
  assign enc_start   = w_accept & (r_wcnt == '0);
  assign enc_data_in = r_owner ? in_data[2*BITS-1:BITS] : in_data[BITS-1:0];
  assign in_ready    = w_load ? (r_owner ? 2'b10 : 2'b01) : 2'b00;

  assign w_qual    = enc_ce & (r_state != S_IDLE);
  assign out_valid = w_qual & (enc_data_bits | enc_ecc_bits);
  assign out_data  = out_valid ? enc_data_out : '0;
  assign out_first = out_valid & enc_first;
  assign out_last  = out_valid & enc_last;
  assign out_ecc   = out_valid & enc_ecc_bits;
  assign out_id    = r_owner;
  assign gnt       = r_gnt;
  assign timeout   = r_timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rr      <= 1'b0;
      r_owner   <= 1'b0;
      r_gnt     <= 2'b00;
      r_timeout <= 1'b0;
      r_wcnt    <= '0;
      r_dcnt    <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if ((|req) && enc_ready) begin
            r_owner <= w_pick;
            r_rr    <= ~w_pick;
            r_gnt   <= w_pick ? 2'b10 : 2'b01;
            r_wcnt  <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            if (r_wcnt == C_WLAST) begin
              r_dcnt  <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_wcnt <= r_wcnt + C_WONE;
            end
          end
        end
        S_DRAIN: begin
          if (enc_last) begin
            r_gnt   <= 2'b00;
            r_state <= S_IDLE;
          end else if (r_dcnt == C_DLAST) begin
            r_timeout <= 1'b1;
            r_gnt     <= 2'b00;
            r_state   <= S_IDLE;
          end else begin
            r_dcnt <= r_dcnt + C_DONE;
          end
        end
        default: begin
          r_gnt   <= 2'b00;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bch_encode_sched.sv
`default_nettype none
// ============================================================================
// tb_bch_encode_sched : directed self-checking bench with a small core model
// Revision 1.0
// ============================================================================
module tb_bch_encode_sched;

  localparam int BITS = 4;
  localparam int DW   = 5;
  localparam int ECC  = 3;
  localparam int DMAX = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req;
  logic [1:0]      gnt;
  logic [1:0]      in_valid;
  logic [2*BITS-1:0] in_data;
  logic [1:0]      in_ready;
  logic            enc_start;
  logic            enc_ce;
  logic [BITS-1:0] enc_data_in;
  logic            enc_ready;
  logic [BITS-1:0] enc_data_out;
  logic            enc_first;
  logic            enc_last;
  logic            enc_data_bits;
  logic            enc_ecc_bits;
  logic            out_valid;
  logic [BITS-1:0] out_data;
  logic            out_first;
  logic            out_last;
  logic            out_ecc;
  logic            out_id;
  logic            timeout;

  int n_total = 0;
  int n_fail  = 0;
  logic no_last = 1'b0;
  logic [BITS-1:0] pat [DW] = '{4'hA, 4'h3, 4'h5, 4'hC, 4'h9};

  always #5 clk = ~clk;

  bch_encode_sched #(.BITS(BITS), .DATA_WORDS(DW), .DRAIN_MAX(DMAX)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .enc_start(enc_start), .enc_ce(enc_ce), .enc_data_in(enc_data_in),
    .enc_ready(enc_ready), .enc_data_out(enc_data_out), .enc_first(enc_first),
    .enc_last(enc_last), .enc_data_bits(enc_data_bits), .enc_ecc_bits(enc_ecc_bits),
    .out_valid(out_valid), .out_data(out_data), .out_first(out_first),
    .out_last(out_last), .out_ecc(out_ecc), .out_id(out_id), .timeout(timeout)
  );

  // Core model: DW data words passed through, then ECC parity words, last on the final one.
  logic [3:0]      mpos;
  logic [3:0]      cur_pos;
  logic [BITS-1:0] par;
  assign cur_pos       = enc_start ? 4'd0 : mpos;
  assign enc_data_bits = (cur_pos < 4'(DW));
  assign enc_ecc_bits  = (cur_pos >= 4'(DW)) && (cur_pos < 4'(DW + ECC));
  assign enc_first     = (cur_pos == 4'd0);
  assign enc_last      = !no_last && (cur_pos == 4'(DW + ECC - 1));
  assign enc_data_out  = enc_data_bits ? enc_data_in : (par ^ cur_pos);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mpos <= 4'd0;
      par  <= '0;
    end else if (enc_ce) begin
      if (cur_pos != 4'hF) mpos <= cur_pos + 4'd1;
      if (enc_data_bits) par <= (enc_start ? '0 : par) ^ enc_data_in;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered one cycle after the grant edge; returns once gnt has dropped.
  task automatic frame(input int id, input int gap_at, input int gap_len, input bit to_mode);
    int dc;
    logic [1:0] oh;
    logic [BITS-1:0] d;
    oh = (id == 0) ? 2'b01 : 2'b10;
    for (int w = 0; w < DW; w++) begin
      if (w == gap_at) begin
        in_valid[id] = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          #1;
          chk("gap_ce", 32'(enc_ce), 32'd0);
          chk("gap_rdy", 32'(in_ready), 32'(oh));
          step();
        end
      end
      d = pat[w] ^ BITS'(id);
      in_valid[id] = 1'b1;
      in_data[id*BITS +: BITS] = d;
      #1;
      chk("ld_ce", 32'(enc_ce), 32'd1);
      chk("ld_start", 32'(enc_start), (w == 0) ? 32'd1 : 32'd0);
      chk("ld_din", 32'(enc_data_in), 32'(d));
      chk("ld_rdy", 32'(in_ready), 32'(oh));
      chk("ld_gnt", 32'(gnt), 32'(oh));
      chk("ld_oval", 32'(out_valid), 32'd1);
      chk("ld_odata", 32'(out_data), 32'(d));
      chk("ld_ofirst", 32'(out_first), (w == 0) ? 32'd1 : 32'd0);
      chk("ld_oid", 32'(out_id), 32'(id));
      step();
    end
    in_valid[id] = 1'b0;
    chk("dr_rdy", 32'(in_ready), 32'd0);
    dc = 0;
    while (gnt != 2'b00 && dc < 20) begin
      chk("dr_ce", 32'(enc_ce), 32'd1);
      chk("dr_to", 32'(timeout), 32'd0);
      chk("dr_oid", 32'(out_id), 32'(id));
      if (!to_mode) begin
        chk("dr_ecc", 32'(out_ecc), 32'd1);
        chk("dr_odata", 32'(out_data), 32'(enc_data_out));
        chk("dr_last", 32'(out_last), (dc == ECC - 1) ? 32'd1 : 32'd0);
      end
      dc++;
      step();
    end
    chk("drain_len", 32'(dc), to_mode ? 32'(DMAX) : 32'(ECC));
    chk("to_pulse", 32'(timeout), to_mode ? 32'd1 : 32'd0);
    chk("rel_ce", 32'(enc_ce), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 2'b00; in_valid = 2'b00; in_data = '0; enc_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    chk("rst_ce", 32'(enc_ce), 32'd0);
    chk("rst_start", 32'(enc_start), 32'd0);
    chk("rst_oval", 32'(out_valid), 32'd0);
    chk("rst_to", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_gnt", 32'(gnt), 32'd0);

    // Single frame from requester 0: grant one edge after req.
    req = 2'b01;
    step();
    chk("t1_gnt", 32'(gnt), 32'd1);
    chk("t1_rdy", 32'(in_ready), 32'd1);
    req = 2'b00;
    frame(0, -1, 0, 1'b0);

    // Requester 1 with a 3-cycle valid gap after word 2.
    req = 2'b10;
    step();
    chk("t3_gnt", 32'(gnt), 32'd2);
    req = 2'b00;
    frame(1, 3, 3, 1'b0);

    // Both requesting: pointer is back at 0, so 0,1,0,1 with one idle cycle between.
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t2_gnt", 32'(gnt), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k == 3) req = 2'b00;
      frame(k % 2, -1, 0, 1'b0);
    end

    // Core never signals last: timeout after DMAX drain cycles, then regrant.
    no_last = 1'b1;
    req = 2'b01;
    step();
    chk("to_gnt", 32'(gnt), 32'd1);
    frame(0, -1, 0, 1'b1);
    no_last = 1'b0;
    step();
    chk("to_clear", 32'(timeout), 32'd0);
    chk("to_regnt", 32'(gnt), 32'd1);
    req = 2'b00;
    frame(0, -1, 0, 1'b0);

    // Core busy blocks granting.
    enc_ready = 1'b0;
    req = 2'b01;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rdy_block", 32'(gnt), 32'd0);
    end
    enc_ready = 1'b1;
    step();
    chk("rdy_gnt", 32'(gnt), 32'd1);
    req = 2'b00;
    frame(0, -1, 0, 1'b0);

    // Reset during word 3 of a frame (pointer currently 1).
    req = 2'b01;
    step();
    chk("mr_gnt", 32'(gnt), 32'd1);
    req = 2'b00;
    in_valid = 2'b01;
    for (int w = 0; w < 3; w++) begin
      in_data[BITS-1:0] = pat[w];
      step();
    end
    in_data[BITS-1:0] = pat[3];
    rst_n = 1'b0;
    step();
    chk("mr_gnt0", 32'(gnt), 32'd0);
    chk("mr_ce", 32'(enc_ce), 32'd0);
    chk("mr_rdy", 32'(in_ready), 32'd0);
    chk("mr_oval", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    in_valid = 2'b00;
    step();
    req = 2'b11;
    step();
    chk("mr_rr", 32'(gnt), 32'd1);
    req = 2'b00;
    frame(0, -1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
`default_nettype wire
